// File: rtl/regfile_writeback_arbiter_pkg.sv
// Shared types and widths for the register-file writeback arbiter and its MDU FIFO.
package regfile_writeback_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] wr_reg;
        logic [DATA_W-1:0]     data;
    } wb_req_t;

endpackage

// File: rtl/regfile_writeback_arbiter_wb_fifo.sv
// DEPTH-entry FIFO of MDU writeback requests; exposes per-slot valid/register
// vectors so the top can build the pending-write scoreboard.
module regfile_writeback_arbiter_wb_fifo
    import regfile_writeback_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                                clock,
    input  logic                                reset_n,
    input  logic                                push_i,
    input  wb_req_t                             push_req_i,
    input  logic                                pop_i,
    output wb_req_t                             head_o,
    output logic                                full_o,
    output logic                                empty_o,
    output logic [$clog2(DEPTH):0]              count_o,
    output logic [DEPTH-1:0]                    entry_valid_o,
    output logic [DEPTH-1:0][REG_ADDR_W-1:0]    entry_reg_o
);

    localparam int AW = $clog2(DEPTH);

    wb_req_t          mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic [DEPTH-1:0] valid_q, valid_d;

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        valid_d = valid_q;
        if (pop_i)  valid_d[rd_ptr_q] = 1'b0;
        if (push_i) valid_d[wr_ptr_q] = 1'b1;
        count_d = count_q + {{AW{1'b0}}, push_i} - {{AW{1'b0}}, pop_i};
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; valid_q alone decides which slots are live.
    always_ff @(posedge clock) begin
        if (push_i) mem_q[wr_ptr_q] <= push_req_i;
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entry_reg_o[i] = mem_q[i].wr_reg;
        end
    end

    assign head_o        = mem_q[rd_ptr_q];
    assign full_o        = (count_q == (AW+1)'(DEPTH));
    assign empty_o       = (count_q == '0);
    assign count_o       = count_q;
    assign entry_valid_o = valid_q;

endmodule

// File: rtl/regfile_writeback_arbiter.sv
// Single-port register-file writeback arbiter: ALU writeback has priority,
// MDU results queue in a FIFO, with starvation stall and pending-write scoreboard.
module regfile_writeback_arbiter
    import regfile_writeback_arbiter_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        alu_wr_en,
    input  logic [REG_ADDR_W-1:0]       alu_wr_reg,
    input  logic [DATA_W-1:0]           alu_wr_data,
    output logic                        alu_stall,
    input  logic                        mdu_valid,
    output logic                        mdu_ready,
    input  logic [REG_ADDR_W-1:0]       mdu_reg,
    input  logic [DATA_W-1:0]           mdu_data,
    input  logic [REG_ADDR_W-1:0]       query_reg1,
    input  logic [REG_ADDR_W-1:0]       query_reg2,
    output logic                        busy1,
    output logic                        busy2,
    output logic [$clog2(DEPTH):0]      fifo_count,
    output logic                        RegWrite,
    output logic [REG_ADDR_W-1:0]       write_reg,
    output logic [DATA_W-1:0]           write_data
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    wb_req_t                          head;
    logic                             fifo_full, fifo_empty;
    logic [DEPTH-1:0]                 entry_valid;
    logic [DEPTH-1:0][REG_ADDR_W-1:0] entry_reg;

    logic alu_win, fifo_push, fifo_pop;

    logic                  reg_write_q;
    logic [REG_ADDR_W-1:0] write_reg_q;
    logic [DATA_W-1:0]     write_data_q;
    logic [SW-1:0]         starve_q, starve_d;
    logic                  alu_stall_q;
    logic                  busy1_c, busy2_c;

    // Writes to $0 are dropped on both sources; an MDU $0 result still handshakes.
    assign alu_win   = alu_wr_en && (alu_wr_reg != ZERO_REG);
    assign fifo_pop  = !alu_win && !fifo_empty;
    assign mdu_ready = !fifo_full;
    assign fifo_push = mdu_valid && mdu_ready && (mdu_reg != ZERO_REG);

    regfile_writeback_arbiter_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock         (clock),
        .reset_n       (reset_n),
        .push_i        (fifo_push),
        .push_req_i    ('{wr_reg: mdu_reg, data: mdu_data}),
        .pop_i         (fifo_pop),
        .head_o        (head),
        .full_o        (fifo_full),
        .empty_o       (fifo_empty),
        .count_o       (fifo_count),
        .entry_valid_o (entry_valid),
        .entry_reg_o   (entry_reg)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            reg_write_q  <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
        end else begin
            reg_write_q <= alu_win || fifo_pop;
            if (alu_win) begin
                write_reg_q  <= alu_wr_reg;
                write_data_q <= alu_wr_data;
            end else if (fifo_pop) begin
                write_reg_q  <= head.wr_reg;
                write_data_q <= head.data;
            end
        end
    end

    // Counts consecutive edges the queued head lost to the ALU; saturates at the limit.
    always_comb begin
        starve_d = starve_q;
        if (fifo_pop || fifo_empty) begin
            starve_d = '0;
        end else if (alu_win && (starve_q < SW'(STARVE_LIMIT))) begin
            starve_d = starve_q + SW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            starve_q    <= '0;
            alu_stall_q <= 1'b0;
        end else begin
            starve_q    <= starve_d;
            alu_stall_q <= (starve_d >= SW'(STARVE_LIMIT));
        end
    end

    // A popping entry still reads busy: its register-file write lands one edge later.
    always_comb begin
        busy1_c = 1'b0;
        busy2_c = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i] && (entry_reg[i] == query_reg1)) busy1_c = 1'b1;
            if (entry_valid[i] && (entry_reg[i] == query_reg2)) busy2_c = 1'b1;
        end
    end

    assign busy1      = busy1_c && (query_reg1 != ZERO_REG);
    assign busy2      = busy2_c && (query_reg2 != ZERO_REG);
    assign alu_stall  = alu_stall_q;
    assign RegWrite   = reg_write_q;
    assign write_reg  = write_reg_q;
    assign write_data = write_data_q;

    // The pipeline must honour alu_stall; the ALU still wins if it does not.
    alu_stall_protocol: assert property (
        @(posedge clock) disable iff (!reset_n) !(alu_wr_en && alu_stall_q)
    );

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Scoreboard bench: a reference queue model predicts each register-file write,
// expected writes are queued at drive time and compared when the DUT emits them.
module tb_regfile_writeback_arbiter;

    localparam int DEPTH = 4;
    localparam int LIMIT = 3;

    typedef struct packed {
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;

    logic        clock, reset_n;
    logic        alu_wr_en, alu_stall, mdu_valid, mdu_ready;
    logic [4:0]  alu_wr_reg, mdu_reg, query_reg1, query_reg2, write_reg;
    logic [31:0] alu_wr_data, mdu_data, write_data;
    logic        busy1, busy2, RegWrite;
    logic [2:0]  fifo_count;

    regfile_writeback_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .alu_wr_en   (alu_wr_en),
        .alu_wr_reg  (alu_wr_reg),
        .alu_wr_data (alu_wr_data),
        .alu_stall   (alu_stall),
        .mdu_valid   (mdu_valid),
        .mdu_ready   (mdu_ready),
        .mdu_reg     (mdu_reg),
        .mdu_data    (mdu_data),
        .query_reg1  (query_reg1),
        .query_reg2  (query_reg2),
        .busy1       (busy1),
        .busy2       (busy2),
        .fifo_count  (fifo_count),
        .RegWrite    (RegWrite),
        .write_reg   (write_reg),
        .write_data  (write_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int   total = 0;
    int   bad   = 0;
    ent_t mq[$];      // model of queued MDU entries
    ent_t exp_q[$];   // expected register-file writes
    ent_t last_w;
    int   m_starve;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    function automatic logic model_busy(input logic [4:0] q);
        if (q == 5'd0) return 1'b0;
        foreach (mq[i]) if (mq[i].r == q) return 1'b1;
        return 1'b0;
    endfunction

    // One clock: drive inputs, check combinational/registered state, advance the model, check the write.
    task automatic step(input logic en, input logic [4:0] ar, input logic [31:0] ad,
                        input logic mv, input logic [4:0] mr, input logic [31:0] md,
                        input logic [4:0] q1, input logic [4:0] q2, output logic accepted);
        logic win, mready, nonempty, popped;
        ent_t e;
        alu_wr_en = en; alu_wr_reg = ar; alu_wr_data = ad;
        mdu_valid = mv; mdu_reg = mr;    mdu_data = md;
        query_reg1 = q1; query_reg2 = q2;
        #1;
        mready   = (mq.size() < DEPTH);
        nonempty = (mq.size() > 0);
        check("mdu_ready",  mdu_ready,  mready);
        check("fifo_count", fifo_count, mq.size());
        check("busy1",      busy1,      model_busy(q1));
        check("busy2",      busy2,      model_busy(q2));
        check("alu_stall",  alu_stall,  m_starve >= LIMIT);
        win    = en && (ar != 5'd0);
        popped = 1'b0;
        if (win) begin
            exp_q.push_back('{r: ar, d: ad});
        end else if (nonempty) begin
            exp_q.push_back(mq.pop_front());
            popped = 1'b1;
        end
        if (popped || !nonempty) m_starve = 0;
        else if (win && m_starve < LIMIT) m_starve++;
        accepted = mv && mready;
        if (accepted && mr != 5'd0) mq.push_back('{r: mr, d: md});
        @(posedge clock);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("RegWrite",   RegWrite,   1'b1);
            check("write_reg",  write_reg,  e.r);
            check("write_data", write_data, e.d);
            last_w = e;
        end else begin
            check("RegWrite_idle",   RegWrite,   1'b0);
            check("write_reg_hold",  write_reg,  last_w.r);
            check("write_data_hold", write_data, last_w.d);
        end
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, acc);
    endtask

    initial begin
        logic acc;
        int   pushed, cyc;
        logic draining;
        last_w   = '0;
        m_starve = 0;
        reset_n  = 1'b0;
        alu_wr_en = 0; alu_wr_reg = 0; alu_wr_data = 0;
        mdu_valid = 0; mdu_reg = 0; mdu_data = 0;
        query_reg1 = 0; query_reg2 = 0;
        #2;
        check("rst_RegWrite",   RegWrite,   1'b0);
        check("rst_write_reg",  write_reg,  5'd0);
        check("rst_write_data", write_data, 32'd0);
        check("rst_fifo_count", fifo_count, 3'd0);
        check("rst_alu_stall",  alu_stall,  1'b0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        check("rel_mdu_ready", mdu_ready, 1'b1);

        // 1: single ALU write, then idle
        step(1, 5, 32'hA5, 0, 0, 0, 0, 0, acc);
        idle(1);

        // 2: one MDU entry with the ALU idle
        step(0, 0, 0, 1, 9, 64, 9, 0, acc);
        step(0, 0, 0, 0, 0, 0, 9, 3, acc);
        idle(1);

        // 3: fill the FIFO under constant ALU traffic, stall, then drain
        pushed = 0; cyc = 0; draining = 1'b0;
        while ((pushed < 4 || mq.size() > 0) && cyc < 40) begin
            if (m_starve >= LIMIT) draining = 1'b1;
            step(!draining, 5'(1 + cyc), $urandom, pushed < 4, 5'(11 + pushed),
                 32'h1000 + 32'(pushed), 11, 14, acc);
            if (acc) begin
                pushed++;
                if (pushed == 4) check("t3_full_ready", mdu_ready, 1'b0);
            end
            cyc++;
        end
        check("t3_drain", fifo_count, 3'd0);
        idle(1);

        // 4: ALU targets $0 so the queued entry drains; MDU push to $0 is accepted but dropped
        step(1, 3, 32'h33, 1, 20, 5, 20, 0, acc);
        step(1, 0, 32'hDEAD, 1, 0, 32'hBEEF, 20, 0, acc);
        check("t4_zero_ack", acc, 1'b1);
        check("t4_count", fifo_count, 3'd0);
        idle(1);

        // 5: push and pop together at count 2 across the pointer wrap
        step(1, 7, 32'h77, 1, 1, 32'hA1, 1, 2, acc);
        step(1, 8, 32'h88, 1, 2, 32'hA2, 1, 2, acc);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 1, 5'(3 + i), 32'hA3 + 32'(i), 5'(1 + i), 5'(3 + i), acc);
            check("t5_count", fifo_count, 3'd2);
        end
        idle(3);

        // 6: reset with queued entries and a write in flight
        step(1, 10, 32'h10, 1, 21, 32'h21, 21, 22, acc);
        step(1, 11, 32'h11, 1, 22, 32'h22, 21, 22, acc);
        step(1, 12, 32'h12, 1, 23, 32'h23, 21, 22, acc);
        #1;
        reset_n = 1'b0;
        alu_wr_en = 0; mdu_valid = 0;
        #1;
        check("t6_RegWrite",   RegWrite,   1'b0);
        check("t6_write_reg",  write_reg,  5'd0);
        check("t6_fifo_count", fifo_count, 3'd0);
        check("t6_busy1",      busy1,      1'b0);
        mq.delete();
        exp_q.delete();
        last_w   = '0;
        m_starve = 0;
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        check("t6_mdu_ready", mdu_ready, 1'b1);
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
